// File: rtl/sprite_arb_pkg.sv
// -----------------------------------------------------------------------------
// sprite_arb_pkg
// Shared definitions for the sprite RAM read arbiter.
//   - default values for NUM_REQ, ADDR_W, DATA_W, SPRITE_DEPTH, WR_BURST_MAX
//   - req_id_t : requester index, clog2(NUM_REQ) bits
//   - stage_t  : read pipeline stage tag (valid, id, err)
//   - next_ptr : round-robin pointer advance with wrap at NUM_REQ
// The typedefs are sized from the package defaults. An instance that raises
// NUM_REQ beyond 2**REQ_ID_W needs the package default raised with it.
// -----------------------------------------------------------------------------
package sprite_arb_pkg;

   localparam int NUM_REQ_DEF      = 3;
   localparam int ADDR_W_DEF       = 19;
   localparam int DATA_W_DEF       = 5;
   localparam int SPRITE_DEPTH_DEF = 1440;
   localparam int WR_BURST_MAX_DEF = 4;

   localparam int REQ_ID_W = (NUM_REQ_DEF > 1) ? $clog2(NUM_REQ_DEF) : 1;

   typedef logic [REQ_ID_W-1:0] req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
      logic    err;
   } stage_t;

   // Pointer moves to the requester just after the winner, wrapping at n.
   function automatic req_id_t next_ptr(input req_id_t idx, input int n);
      return (int'(idx) >= n - 1) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/sprite_ram_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: scans req starting at index ptr and
// returns the first asserted request as a one-hot grant.
// Ports:
//   req   in  N      request vector
//   ptr   in  PTR_W  scan start index (expected < N)
//   grant out N      one-hot winner (all zero when no request)
//   valid out 1      a winner exists
// -----------------------------------------------------------------------------
module rr_picker #(
   parameter int N     = 3,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic             valid
);

   int idx;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         // modulo keeps the scan inside the vector even for a stray pointer
         idx = (int'(ptr) + k) % N;
         if (!valid && req[idx]) begin
            grant[idx] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sprite_ram_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_ram_arbiter
// Shares one sprite RAM (1-cycle registered read) between NUM_REQ readers with
// round-robin arbitration, one read per cycle, fixed 2-cycle read latency.
// Addresses >= SPRITE_DEPTH are granted but answered with rd_err=1, rd_data=0.
// Optional loader write port, enabled by macro SPRITE_ARB_WRITE_EN: writes take
// priority, but after WR_BURST_MAX consecutive writes a pending read gets one
// slot. Without the macro the write port is absent and the RAM write side is
// tied off.
// Ports:
//   Clk, Reset              clock, synchronous active-high reset
//   req, req_addr           per-requester read request / address
//   gnt                     one-hot grant, same cycle as acceptance
//   rd_valid/rd_id/rd_data/rd_err  read response, 2 cycles after grant
//   ram_read_address, ram_data_out RAM read port
//   ram_we, ram_write_address, ram_data_in  RAM write port
//   wr_req, wr_addr, wr_data, wr_ack  loader port (SPRITE_ARB_WRITE_EN only)
// -----------------------------------------------------------------------------
module sprite_ram_arbiter
   import sprite_arb_pkg::*;
#(
   parameter int NUM_REQ      = NUM_REQ_DEF,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int SPRITE_DEPTH = SPRITE_DEPTH_DEF,
   parameter int WR_BURST_MAX = WR_BURST_MAX_DEF
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]             gnt,
   output logic                           rd_valid,
   output req_id_t                        rd_id,
   output logic [DATA_W-1:0]              rd_data,
   output logic                           rd_err,
   output logic [ADDR_W-1:0]              ram_read_address,
   input  logic [DATA_W-1:0]              ram_data_out,
`ifdef SPRITE_ARB_WRITE_EN
   input  logic                           wr_req,
   input  logic [ADDR_W-1:0]              wr_addr,
   input  logic [DATA_W-1:0]              wr_data,
   output logic                           wr_ack,
`endif
   output logic                           ram_we,
   output logic [ADDR_W-1:0]              ram_write_address,
   output logic [DATA_W-1:0]              ram_data_in
);

   localparam logic [ADDR_W-1:0] DEPTH_ADDR = ADDR_W'(SPRITE_DEPTH);

   req_id_t             ptr_reg;
   logic [NUM_REQ-1:0]  pick_grant;
   logic                pick_valid;
   logic                write_slot;
   logic                read_fire;
   req_id_t             sel_id;
   logic [ADDR_W-1:0]   sel_addr;
   logic                sel_err;
   logic [ADDR_W-1:0]   addr_hold_reg;
   stage_t              s1_reg;

   rr_picker #(
      .N     (NUM_REQ),
      .PTR_W (REQ_ID_W)
   ) u_picker (
      .req   (req),
      .ptr   (ptr_reg),
      .grant (pick_grant),
      .valid (pick_valid)
   );

   // A read is never granted in a write slot, so read/write collisions on the
   // same address cannot happen.
   assign read_fire = pick_valid && !write_slot && !Reset;
   assign gnt       = read_fire ? pick_grant : '0;

   always_comb begin
      sel_id   = '0;
      sel_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_grant[i]) begin
            sel_id   = req_id_t'(i);
            sel_addr = req_addr[i];
         end
      end
   end

   assign sel_err = (sel_addr >= DEPTH_ADDR);

   // Out-of-range reads keep the last good address on the RAM bus; their
   // response is forced to zero anyway.
   assign ram_read_address = Reset                   ? '0       :
                             (read_fire && !sel_err) ? sel_addr : addr_hold_reg;

   // Stage 1 tags the cycle in which the RAM is fetching; stage 2 is the
   // registered response, so data appears two cycles after the grant.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ptr_reg       <= '0;
         addr_hold_reg <= '0;
         s1_reg        <= '0;
         rd_valid      <= 1'b0;
         rd_id         <= '0;
         rd_data       <= '0;
         rd_err        <= 1'b0;
      end else begin
         if (read_fire) begin
            ptr_reg <= next_ptr(sel_id, NUM_REQ);
         end
         if (read_fire && !sel_err) begin
            addr_hold_reg <= sel_addr;
         end
         s1_reg   <= '{valid: read_fire, id: sel_id, err: sel_err};
         rd_valid <= s1_reg.valid;
         rd_id    <= s1_reg.valid ? s1_reg.id : '0;
         rd_err   <= s1_reg.valid && s1_reg.err;
         rd_data  <= (s1_reg.valid && !s1_reg.err) ? ram_data_out : '0;
      end
   end

`ifdef SPRITE_ARB_WRITE_EN
   localparam int              CNT_W   = $clog2(WR_BURST_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WR_BURST_MAX);

   logic [CNT_W-1:0] wr_cnt_reg;
   logic             burst_full;

   // The counter saturates at the limit: once full, writes continue only
   // while nobody is waiting to read.
   assign burst_full        = (wr_cnt_reg == CNT_MAX);
   assign write_slot        = !Reset && wr_req && !(burst_full && (|req));
   assign wr_ack            = write_slot;
   assign ram_we            = write_slot;
   assign ram_write_address = write_slot ? wr_addr : '0;
   assign ram_data_in       = write_slot ? wr_data : '0;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_cnt_reg <= '0;
      end else if (write_slot) begin
         if (!burst_full) begin
            wr_cnt_reg <= wr_cnt_reg + 1'b1;
         end
      end else begin
         wr_cnt_reg <= '0;
      end
   end
`else
   assign write_slot        = 1'b0;
   assign ram_we            = 1'b0;
   assign ram_write_address = '0;
   assign ram_data_in       = '0;
`endif

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sprite_ram_arbiter
// Directed and randomized stimulus for sprite_ram_arbiter with a behavioural
// reference: round-robin winner search, a queue of expected responses due two
// cycles after each grant, and a shadow copy of the sprite memory.
// The write-path scenarios are compiled in when SPRITE_ARB_WRITE_EN is defined.
// -----------------------------------------------------------------------------
module tb_sprite_ram_arbiter;

   localparam int NR    = 3;
   localparam int AW    = 19;
   localparam int DW    = 5;
   localparam int DEPTH = 1440;
   localparam int BMAX  = 4;

   logic                   Clk = 1'b0;
   logic                   Reset;
   logic [NR-1:0]          req;
   logic [NR-1:0][AW-1:0]  req_addr;
   logic [NR-1:0]          gnt;
   logic                   rd_valid;
   logic [1:0]             rd_id;
   logic [DW-1:0]          rd_data;
   logic                   rd_err;
   logic [AW-1:0]          ram_read_address;
   logic [DW-1:0]          ram_data_out;
   logic                   wr_req;
   logic [AW-1:0]          wr_addr;
   logic [DW-1:0]          wr_data;
   logic                   wr_ack;
   logic                   ram_we;
   logic [AW-1:0]          ram_write_address;
   logic [DW-1:0]          ram_data_in;

   always #5 Clk = ~Clk;

   sprite_ram_arbiter dut (
      .Clk               (Clk),
      .Reset             (Reset),
      .req               (req),
      .req_addr          (req_addr),
      .gnt               (gnt),
      .rd_valid          (rd_valid),
      .rd_id             (rd_id),
      .rd_data           (rd_data),
      .rd_err            (rd_err),
      .ram_read_address  (ram_read_address),
      .ram_data_out      (ram_data_out),
`ifdef SPRITE_ARB_WRITE_EN
      .wr_req            (wr_req),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data),
      .wr_ack            (wr_ack),
`endif
      .ram_we            (ram_we),
      .ram_write_address (ram_write_address),
      .ram_data_in       (ram_data_in)
   );

`ifndef SPRITE_ARB_WRITE_EN
   assign wr_ack = 1'b0;
`endif

   // ---------------- sprite RAM (registered read) ----------------
   int            seed;
   bit            ram_init_done = 1'b0;
   logic [DW-1:0] ram_mem [DEPTH];

   function automatic logic [DW-1:0] pat(input int i);
      return DW'((i * 37 + seed) ^ (i >> 4));
   endfunction

   always @(posedge Clk) begin
      if (!ram_init_done) begin
         for (int i = 0; i < DEPTH; i++) ram_mem[i] <= pat(i);
         ram_init_done <= 1'b1;
      end else begin
         if (ram_we && int'(ram_write_address) < DEPTH)
            ram_mem[int'(ram_write_address)] <= ram_data_in;
         ram_data_out <= (int'(ram_read_address) < DEPTH) ? ram_mem[int'(ram_read_address)] : '0;
      end
   end

   // ---------------- reference model state ----------------
   typedef struct {
      int due;
      int id;
      int data;
      int err;
   } resp_t;

   resp_t         q[$];
   logic [DW-1:0] shadow [DEPTH];
   int            ptr_m, wcnt_m, cyc;
   int            last_win;
   bit            last_wslot;
   bit            chk_en;
   logic          obs_ack, obs_g0;
   int            checks = 0;
   int            errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: inputs are already applied; compare at the falling edge,
   // then advance the model past the rising edge.
   task automatic do_cycle();
      int            win;
      bit            wslot;
      logic [NR-1:0] exp_gnt;
      resp_t         r;
      @(negedge Clk);
      win   = -1;
      wslot = 1'b0;
      if (!Reset) begin
         wslot = wr_req && !(wcnt_m >= BMAX && req != '0);
         if (!wslot) begin
            for (int k = 0; k < NR; k++) begin
               int j;
               j = (ptr_m + k) % NR;
               if (win < 0 && req[j]) win = j;
            end
         end
      end
      exp_gnt = '0;
      if (win >= 0) exp_gnt[win] = 1'b1;
      obs_ack = wr_ack;
      obs_g0  = gnt[0];
      if (chk_en) begin
         check("gnt", 32'(gnt), 32'(exp_gnt));
         check("wr_ack", 32'(wr_ack), 32'(wslot));
         check("ram_we", 32'(ram_we), 32'(wslot));
         if (wslot) begin
            check("ram_write_address", 32'(ram_write_address), 32'(wr_addr));
            check("ram_data_in", 32'(ram_data_in), 32'(wr_data));
         end
         if (win >= 0 && int'(req_addr[win]) < DEPTH)
            check("ram_read_address", 32'(ram_read_address), 32'(req_addr[win]));
         if (Reset) begin
            check("reset_rd_id", 32'(rd_id), 32'd0);
            check("reset_rd_err", 32'(rd_err), 32'd0);
            check("reset_ram_read_address", 32'(ram_read_address), 32'd0);
         end
         if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            check("rd_valid", 32'(rd_valid), 32'd1);
            check("rd_id", 32'(rd_id), 32'(r.id));
            check("rd_data", 32'(rd_data), 32'(r.data));
            check("rd_err", 32'(rd_err), 32'(r.err));
         end else begin
            check("rd_valid_idle", 32'(rd_valid), 32'd0);
            check("rd_data_idle", 32'(rd_data), 32'd0);
         end
      end
      @(posedge Clk);
      #1;
      if (Reset) begin
         q.delete();
         ptr_m  = 0;
         wcnt_m = 0;
      end else begin
         if (win >= 0) begin
            r.due  = cyc + 2;
            r.id   = win;
            r.err  = (int'(req_addr[win]) >= DEPTH) ? 1 : 0;
            r.data = r.err ? 0 : int'(shadow[int'(req_addr[win])]);
            q.push_back(r);
            ptr_m = (win + 1) % NR;
         end
         if (wslot) begin
            shadow[int'(wr_addr)] = wr_data;
            wcnt_m++;
         end else begin
            wcnt_m = 0;
         end
      end
      last_win   = win;
      last_wslot = wslot;
      cyc++;
   endtask

   task automatic idle(input int n);
      req = '0;
      for (int i = 0; i < n; i++) do_cycle();
   endtask

   initial begin
      int acks;
      int seq_code;
      int exp_code;
      int pattern [7];

      seed = int'($urandom);
      for (int i = 0; i < DEPTH; i++) shadow[i] = pat(i);
      Reset = 1'b1; req = '0; req_addr = '0;
      wr_req = 1'b0; wr_addr = '0; wr_data = '0;
      ptr_m = 0; wcnt_m = 0; cyc = 0; last_win = -1; last_wslot = 1'b0;
      chk_en = 1'b0;

      // reset: first cycle outputs are still unknown, the next ones are checked
      do_cycle();
      chk_en = 1'b1;
      do_cycle();
      do_cycle();
      Reset = 1'b0;
      idle(2);

      // all three requesting, held: grants 0,1,2,0,... and a response per cycle
      req = 3'b111;
      req_addr[0] = AW'(10); req_addr[1] = AW'(20); req_addr[2] = AW'(30);
      for (int i = 0; i < 9; i++) do_cycle();
      idle(3);

      // single requester 1 at address 5
      req = 3'b010; req_addr[1] = AW'(5);
      do_cycle();
      idle(3);

      // out-of-range address: granted, answered with error and zero data
      req = 3'b100; req_addr[2] = AW'(DEPTH);
      do_cycle();
      idle(3);

      // reset one cycle after a grant: response discarded, pointer back to 0
      req = 3'b010; req_addr[1] = AW'(7);
      do_cycle();
      req = '0; Reset = 1'b1;
      do_cycle();
      Reset = 1'b0;
      idle(4);
      req = 3'b110; req_addr[1] = AW'(11); req_addr[2] = AW'(12);
      do_cycle();
      idle(3);

`ifdef SPRITE_ARB_WRITE_EN
      // write burst limit with requester 0 waiting
      pattern = '{1, 1, 1, 1, 2, 1, 1};
      exp_code = 0;
      for (int i = 0; i < 7; i++) exp_code = exp_code * 3 + pattern[i];
      seq_code = 0;
      acks = 0;
      req = 3'b001; req_addr[0] = AW'(50);
      wr_req = 1'b1; wr_addr = AW'(100); wr_data = ~shadow[100];
      for (int n = 0; n < 20 && acks < 6; n++) begin
         do_cycle();
         if (obs_ack) seq_code = seq_code * 3 + 1;
         else if (obs_g0) seq_code = seq_code * 3 + 2;
         if (last_win == 0) req[0] = 1'b0;
         if (last_wslot) begin
            acks++;
            if (acks < 6) begin
               wr_addr = AW'(100 + acks);
               wr_data = ~shadow[100 + acks];
            end else begin
               wr_req = 1'b0;
            end
         end
      end
      wr_req = 1'b0;
      check("burst_pattern", 32'(seq_code), 32'(exp_code));
      check("burst_acks", 32'(acks), 32'd6);
      // read back the last written word
      req = 3'b001; req_addr[0] = AW'(105);
      do_cycle();
      idle(3);
`endif

      // randomized traffic
      req = '0;
      for (int n = 0; n < 400; n++) begin
         for (int j = 0; j < NR; j++) begin
            if (req[j] && last_win == j) req[j] = 1'b0;
            else if (!req[j] && $urandom_range(0, 99) < 40) begin
               req[j] = 1'b1;
               req_addr[j] = ($urandom_range(0, 15) == 0)
                             ? AW'(DEPTH + $urandom_range(0, 100))
                             : AW'($urandom_range(0, DEPTH - 1));
            end
         end
`ifdef SPRITE_ARB_WRITE_EN
         if (wr_req && last_wslot) wr_req = 1'b0;
         else if (!wr_req && $urandom_range(0, 99) < 30) begin
            wr_req  = 1'b1;
            wr_addr = AW'($urandom_range(0, DEPTH - 1));
            wr_data = DW'($urandom);
         end
`endif
         do_cycle();
         if (req[0] && last_win == 0) req[0] = 1'b0;
      end
      wr_req = 1'b0;
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
